// File: rtl/sevenseg_text_feeder_if.sv
// sevenseg_text_feeder_if
//   Byte-stream handshake between a message producer (control FSM / UART
//   decoder) and sevenseg_text_feeder.
//   char_in    : ASCII character
//   char_valid : char_in is valid this cycle
//   char_ready : receiver accepts char_in this cycle
//   msg_end    : transferred character is the last of the message
interface sevenseg_text_feeder_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       msg_end;

  modport master (
    output char_in,
    output char_valid,
    output msg_end,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  msg_end,
    output char_ready
  );
endinterface

// File: rtl/sevenseg_text_feeder.sv
// sevenseg_text_feeder
//   Buffers an ASCII message received over a valid/ready byte stream and
//   drives the four ASCII character inputs of a 4-digit seven-segment driver.
//   Messages of up to 4 characters are shown left-justified and space padded;
//   longer ones scroll left with a 4-space gap before wrapping.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_clear      single-cycle synchronous clear (wins over a transfer)
//   io_char      character stream (slave side)
//   o_display_0  leftmost digit ASCII ... o_display_3 rightmost digit ASCII
//   o_busy       high while a message is being loaded
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | nothing buffered, display blank
// S_LOAD   | receiving a message, display holds old content
// S_STATIC | committed message of 4 chars or fewer
// S_SCROLL | committed message longer than 4 chars, scrolling
module sevenseg_text_feeder #(
  parameter int DEPTH      = 16,
  parameter int SCROLL_DIV = 12500000,
  parameter int DIV_W      = 24
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  sevenseg_text_feeder_if.slave  io_char,
  output logic [7:0]             o_display_0,
  output logic [7:0]             o_display_1,
  output logic [7:0]             o_display_2,
  output logic [7:0]             o_display_3,
  output logic                   o_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for pos + 3 with pos < len + 4 <= DEPTH + 4.
  localparam int W  = $clog2(DEPTH + 8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STATIC,
    S_SCROLL
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_buf [DEPTH];
  logic [W-1:0]     r_len;
  logic [W-1:0]     r_pos;
  logic [DIV_W-1:0] r_div;
  logic             r_ready;
  logic [7:0]       r_disp [4];
  logic [7:0]       w_disp [4];
  logic [W-1:0]     w_idx;
  logic [W-1:0]     w_period;
  logic [W-1:0]     w_len_inc;
  logic [W-1:0]     w_new_len;
  logic [AW-1:0]    w_wr_addr;
  logic             w_xfer;
  logic             w_commit;
  logic             w_div_tc;

  // A clear cycle drops any concurrent character.
  assign w_xfer    = io_char.char_valid & r_ready & ~i_clear;
  assign w_len_inc = r_len + W'(1);
  assign w_period  = r_len + W'(4);
  assign w_div_tc  = (r_div == DIV_W'(SCROLL_DIV - 1));

  // Outside LOAD a transfer starts a fresh message at buffer[0].
  assign w_new_len = (r_state == S_LOAD) ? w_len_inc : W'(1);
  assign w_wr_addr = (r_state == S_LOAD) ? r_len[AW-1:0] : '0;
  assign w_commit  = w_xfer & (io_char.msg_end | (w_new_len == W'(DEPTH)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_xfer) begin
      if (w_commit) w_state_nxt = (w_new_len <= W'(4)) ? S_STATIC : S_SCROLL;
      else          w_state_nxt = S_LOAD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_xfer) r_buf[w_wr_addr] <= io_char.char_in;
  end

  // Window over V = buffer[0..len-1] + 4 spaces. pos + i < 2*P always, so
  // one conditional subtract gives the modulo. With len <= 4 and pos = 0
  // this reduces to the static left-justified view; with len = 0, all blank.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_pos + W'(i);
      if (w_idx >= w_period) w_idx = w_idx - w_period;
      w_disp[i] = (w_idx < r_len) ? r_buf[w_idx[AW-1:0]] : 8'h20;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len   <= '0;
      r_pos   <= '0;
      r_div   <= '0;
      r_ready <= 1'b0;
      for (int i = 0; i < 4; i++) r_disp[i] <= 8'h20;
    end else begin
      r_ready <= 1'b1;
      if (i_clear) begin
        r_len <= '0;
        r_pos <= '0;
        r_div <= '0;
      end else if (w_xfer) begin
        r_len <= w_new_len;
        r_pos <= '0;
        r_div <= '0;
      end else if (r_state == S_SCROLL) begin
        if (w_div_tc) begin
          r_div <= '0;
          r_pos <= (r_pos == w_period - W'(1)) ? '0 : r_pos + W'(1);
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end

      // Display follows registered state, so a commit shows one edge later
      // and LOAD keeps the previous message on screen.
      if (i_clear) begin
        for (int i = 0; i < 4; i++) r_disp[i] <= 8'h20;
      end else if (r_state != S_LOAD) begin
        for (int i = 0; i < 4; i++) r_disp[i] <= w_disp[i];
      end
    end
  end

  assign io_char.char_ready = r_ready;
  assign o_busy             = (r_state == S_LOAD);
  assign o_display_0        = r_disp[0];
  assign o_display_1        = r_disp[1];
  assign o_display_2        = r_disp[2];
  assign o_display_3        = r_disp[3];

endmodule

// File: tb/tb_sevenseg_text_feeder.sv
module tb_sevenseg_text_feeder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] d0, d1, d2, d3;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  sevenseg_text_feeder_if bus();

  sevenseg_text_feeder #(
    .DEPTH(16),
    .SCROLL_DIV(4),
    .DIV_W(24)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_clear(clear),
    .io_char(bus),
    .o_display_0(d0),
    .o_display_1(d1),
    .o_display_2(d2),
    .o_display_3(d3),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] disp();
    return {d0, d1, d2, d3};
  endfunction

  task automatic send(input logic [7:0] c, input logic e);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    bus.msg_end    = e;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    bus.msg_end    = 1'b0;
  endtask

  task automatic test_reset();
    bus.char_in = 8'h00; bus.char_valid = 1'b0; bus.msg_end = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL reset_disp: got %h want 20202020", disp()); end
    checks++;
    if (bus.char_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.char_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.char_ready !== 1'b1) begin errors++; $display("FAIL reset_rel_ready: got %b want 1", bus.char_ready); end
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL reset_rel_disp: got %h want 20202020", disp()); end
  endtask

  task automatic test_static();
    @(negedge clk);
    send(8'h48, 1'b0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL static_busy_load: got %b want 1", busy); end
    send(8'h49, 1'b1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL static_busy_commit: got %b want 0", busy); end
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL static_latency: got %h want 20202020", disp()); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp() !== 32'h48492020) begin errors++; $display("FAIL static_hi: got %h want 48492020", disp()); end
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp() !== 32'h48492020) begin errors++; $display("FAIL static_hold: got %h want 48492020", disp()); end
  endtask

  task automatic test_scroll();
    logic [31:0] exp_win [10];
    exp_win = '{"HELL", "ELLO", "LLO ", "LO  ", "O   ", "    ", "   H", "  HE", " HEL", "HELL"};
    @(negedge clk);
    send("H", 1'b0);
    send("E", 1'b0);
    send("L", 1'b0);
    send("L", 1'b0);
    send("O", 1'b1);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (disp() !== exp_win[k]) begin
          errors++;
          $display("FAIL scroll_win%0d_cyc%0d: got %h want %h", k, c, disp(), exp_win[k]);
        end
        @(posedge clk);
      end
    end
  endtask

  task automatic test_scroll_interrupt();
    @(negedge clk);
    send(8'h50, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (disp() !== 32'h50202020) begin
        errors++;
        $display("FAIL interrupt_p_cyc%0d: got %h want 50202020", c, disp());
      end
    end
  endtask

  task automatic test_depth();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.char_in    = 8'(8'h61 + i);
      bus.char_valid = 1'b1;
      bus.msg_end    = 1'b0;
      #1;
      checks++;
      if (bus.char_ready !== 1'b1) begin errors++; $display("FAIL depth_ready_%0d: got %b want 1", i, bus.char_ready); end
      checks++;
      if (busy !== ((i >= 1) && (i != 16))) begin
        errors++;
        $display("FAIL depth_busy_%0d: got %b want %b", i, busy, ((i >= 1) && (i != 16)));
      end
      @(posedge clk);
    end
    #1;
    bus.char_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL depth_busy_after: got %b want 1", busy); end
    checks++;
    if (disp() !== 32'h61626364) begin errors++; $display("FAIL depth_first_msg: got %h want 61626364", disp()); end
    send(8'h75, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp() !== 32'h71727374) begin errors++; $display("FAIL depth_second_w0: got %h want 71727374", disp()); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp() !== 32'h72737475) begin errors++; $display("FAIL depth_second_w1: got %h want 72737475", disp()); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    send(8'h78, 1'b0);
    send(8'h79, 1'b0);
    send(8'h7A, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL clear_disp: got %h want 20202020", disp()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b want 0", busy); end
    checks++;
    if (bus.char_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", bus.char_ready); end
    send(8'h43, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (disp() !== 32'h43202020) begin errors++; $display("FAIL clear_then_c: got %h want 43202020", disp()); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    send("H", 1'b0);
    send("E", 1'b0);
    send("L", 1'b0);
    send("L", 1'b0);
    send("O", 1'b1);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL areset_disp: got %h want 20202020", disp()); end
    checks++;
    if (bus.char_ready !== 1'b0) begin errors++; $display("FAIL areset_ready: got %b want 0", bus.char_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
    #7;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.char_ready !== 1'b0) begin errors++; $display("FAIL areset_ready_preclk: got %b want 0", bus.char_ready); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.char_ready !== 1'b1) begin errors++; $display("FAIL areset_ready_post: got %b want 1", bus.char_ready); end
    checks++;
    if (disp() !== 32'h20202020) begin errors++; $display("FAIL areset_disp_post: got %h want 20202020", disp()); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_scroll();
    test_scroll_interrupt();
    test_depth();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_text_feeder.md
Name: sevenseg_text_feeder

Overview:
- Producer side of the 4-digit seven-segment display interface: accepts an ASCII message over a valid/ready byte stream, buffers it, and drives the four 8-bit ASCII character inputs of the display driver.
- Messages of 4 characters or fewer are shown statically, left-justified and space-padded.
- Longer messages scroll left continuously at a programmable rate, with a 4-space gap before they wrap.
- Sits between control logic (FSM/UART decoder) and the seven-segment display driver, in the same clock domain.

Parameters:
- DEPTH, 16, message buffer size in characters; must be at least 5.
- SCROLL_DIV, 12500000, clk cycles per scroll step; must be at least 1.
- DIV_W, 24, width of the scroll divider counter; must satisfy 2^DIV_W > SCROLL_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid this cycle.
- char_ready  out  1  block accepts char_in this cycle; a transfer happens when valid and ready are both 1.
- msg_end  in  1  qualified by the transfer; marks the transferred char as the last of the message.
- clear  in  1  single-cycle synchronous clear.
- display_0  out  8  leftmost digit ASCII.
- display_1  out  8  second digit.
- display_2  out  8  third digit.
- display_3  out  8  rightmost digit.
- busy  out  1  high while a message is being loaded.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; len=0; window start pos=0; divider=0.
  - display_0..3=8'h20; busy=0; char_ready=0 while rst_n=0.
- States:
  - IDLE: nothing buffered. char_ready=1.
  - LOAD: receiving a message. char_ready=1; busy=1.
  - STATIC: message with len≤4. char_ready=1.
  - SCROLL: message with len>4. char_ready=1.
- Transfer in IDLE/STATIC/SCROLL:
  - Discards the old message; buffer[0]=char_in; len=1.
  - Goes to LOAD, unless msg_end=1, in which case it commits immediately (len=1).
  - display_* hold their previous values throughout LOAD.
- Transfer in LOAD:
  - buffer[len]=char_in; len+1.
  - Commit on msg_end=1, or automatically when the transfer brings len to DEPTH (excess characters are never accepted).
- Commit:
  - Next state is STATIC if len≤4, else SCROLL.
  - pos=0; divider=0.
  - display_* updated on the clock edge following the commit edge, i.e. 1 cycle latency.
- STATIC:
  - display_i = buffer[i] for i<len, else 8'h20.
  - Constant until the next transfer or clear.
- SCROLL:
  - Virtual string V = buffer[0..len-1] followed by 4 x 8'h20; period P = len+4.
  - display_i = V[(pos+i) mod P].
  - Divider counts 0..SCROLL_DIV-1. On the cycle it equals SCROLL_DIV-1 it returns to 0 and pos advances: pos = (pos+1) mod P.
  - display_* reflect the new pos 1 cycle later.
  - First window after commit is pos=0 and is held for SCROLL_DIV cycles.
  - Wrap: pos=P-1 goes to 0. The sequence repeats indefinitely.
- clear=1:
  - Highest priority. Next state IDLE; len=0; pos=0; divider=0; display_*=8'h20 next cycle.
  - A concurrent transfer is ignored (char_ready is still 1 that cycle, but the char is dropped); callers must not assert clear with char_valid.
- Characters are passed through unmodified; unsupported codes are the display driver's concern.
- All outputs registered. char_ready and busy are decoded from registered state only, with no combinational path from char_valid.

Test Plan:
- Reset, then send "HI" (8'h48, 8'h49 with msg_end) -> after commit+1: display_0..3 = 48,49,20,20; state STATIC; busy=0; outputs unchanged after 100 cycles.
- SCROLL_DIV=4, send "HELLO" -> sequence:
  - windows "HELL","ELLO","LLO ","LO  ","O   ","    ","   H","  HE"," HEL", then back to "HELL";
  - each window held exactly 4 cycles; P=9.
- DEPTH=16, stream 20 chars without msg_end -> char_ready still high on the 16th transfer, which auto-commits; chars 17-20 begin a new LOAD; verify no char lost beyond that protocol.
- During SCROLL, send "P" with msg_end -> display switches to 50,20,20,20 one cycle after commit; the old message never reappears.
- During LOAD after 3 chars, pulse clear -> next cycle: display all 8'h20, busy=0, IDLE; the next "C"+msg_end displays 43,20,20,20.
- Assert rst_n=0 asynchronously mid-SCROLL (not clock-aligned) -> display_* = 8'h20 and char_ready=0 immediately; after release, IDLE with char_ready=1 on the first clock.
